lab1_memtest_master: RTL and testbench

Avalon-MM master that exercises a memory slave such as the on-chip RAM in the lab1 system. On `start` it fills a word-aligned region with a deterministic pattern, then reads the region back one word at a time and compares. It reports pass/fail, a saturating error count and the first failing address. It sits on the system interconnect as an initiator and is used for bring-up and regression of RAM slaves.

---
 rtl/lab1_memtest_pkg.sv | 31 +++
 rtl/lab1_memtest_pattern.sv | 76 +++++++
 rtl/lab1_memtest_master.sv | 165 ++++++++++++++++
 tb/tb_lab1_memtest_master.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab1_memtest_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lab1_memtest_pkg
// Purpose  : Shared types and constants for the lab1 memory-test master:
//            FSM state encoding, LFSR feedback polynomial, default widths.
// Revision : 1.0 - initial release
// ============================================================================
package lab1_memtest_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LEN_W  = 14;
  localparam int DEF_ERR_W  = 16;

  // Feedback taps for x^32 + x^22 + x^2 + x + 1 (right-shifting Galois form)
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_RWAIT = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // One Galois step: shift right, fold the bit shifted out back through the taps
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lab1_memtest_pattern.sv
`default_nettype none
// ============================================================================
// Module   : lab1_memtest_pattern
// Purpose  : Test-pattern generator P(i). load restarts the sequence at word
//            0 from seed_i, step advances to the next word.
//            MEMTEST_LFSR_EN defined : 32-bit Galois LFSR seeded with seed_i
//                                      (a zero seed is replaced by 1).
//            MEMTEST_LFSR_EN undefined: P(i) = seed XOR zero-extended i.
// Revision : 1.0 - initial release
// ============================================================================
module lab1_memtest_pattern import lab1_memtest_pkg::*; #(
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] seed_i,
  output logic [31:0] pattern_o
);

`ifdef MEMTEST_LFSR_EN
  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  // Next LFSR value: load wins over step so a reload always restarts at P(0)
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = (seed_i == 32'h0) ? 32'h1 : seed_i;
    end else if (step_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  // LFSR state register
  always_ff @(posedge clk) begin
    if (!reset_n) lfsr_q <= '0;
    else          lfsr_q <= lfsr_d;
  end

  assign pattern_o = lfsr_q;
`else
  logic [31:0]      seed_q;
  logic [31:0]      seed_d;
  logic [LEN_W-1:0] idx_q;
  logic [LEN_W-1:0] idx_d;

  // Local word index and seed copy; load restarts at word 0
  always_comb begin
    seed_d = seed_q;
    idx_d  = idx_q;
    if (load_i) begin
      seed_d = seed_i;
      idx_d  = '0;
    end else if (step_i) begin
      idx_d  = idx_q + LEN_W'(1);
    end
  end

  // Seed/index registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seed_q <= '0;
      idx_q  <= '0;
    end else begin
      seed_q <= seed_d;
      idx_q  <= idx_d;
    end
  end

  assign pattern_o = seed_q ^ 32'(idx_q);
`endif

endmodule
`default_nettype wire

// File: rtl/lab1_memtest_master.sv
`default_nettype none
// ============================================================================
// Module   : lab1_memtest_master
// Purpose  : Avalon-MM memory-test initiator. Writes P(i) to a word-aligned
//            region, reads it back one word at a time (one read outstanding)
//            and reports pass/fail, saturating error count and the first
//            failing byte address. Pattern source selected by MEMTEST_LFSR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lab1_memtest_master import lab1_memtest_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int ERR_W  = DEF_ERR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_words,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [31:0]       seed_q, seed_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] ferr_q, ferr_d;

  logic              w_start_acc;
  logic              w_last;
  logic [ADDR_W-1:0] w_cur_addr;
  logic              w_pat_load;
  logic              w_pat_step;
  logic [31:0]       w_pat_seed;
  logic [31:0]       w_pattern;

  assign w_start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign w_last      = (idx_q == (len_q - LEN_W'(1)));
  // Byte address of the current word; wraps naturally at 2^ADDR_W
  assign w_cur_addr  = base_q + ADDR_W'({idx_q, 2'b00});
  // At start the new seed is not registered yet, so feed it straight through
  assign w_pat_seed  = w_start_acc ? seed : seed_q;

  lab1_memtest_pattern #(
    .LEN_W (LEN_W)
  ) u_pattern (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (w_pat_load),
    .step_i    (w_pat_step),
    .seed_i    (w_pat_seed),
    .pattern_o (w_pattern)
  );

  // Next-state, index, result and pattern-control logic
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    seed_d     = seed_q;
    idx_d      = idx_q;
    err_d      = err_q;
    ferr_d     = ferr_q;
    w_pat_load = 1'b0;
    w_pat_step = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          base_d     = base_addr & ~ADDR_W'(3);
          len_d      = num_words;
          seed_d     = seed;
          idx_d      = '0;
          err_d      = '0;
          ferr_d     = '0;
          w_pat_load = 1'b1;
          state_d    = (num_words == '0) ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        if (!avm_waitrequest) begin
          if (w_last) begin
            // Rewind index and pattern for the read-back pass
            idx_d      = '0;
            w_pat_load = 1'b1;
            state_d    = S_READ;
          end else begin
            idx_d      = idx_q + LEN_W'(1);
            w_pat_step = 1'b1;
          end
        end
      end
      S_READ: begin
        if (!avm_waitrequest) state_d = S_RWAIT;
      end
      S_RWAIT: begin
        if (avm_readdatavalid) begin
          if (avm_readdata != w_pattern) begin
            if (err_q == '0)          ferr_d = w_cur_addr;
            if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
          end
          if (w_last) begin
            state_d = S_DONE;
          end else begin
            idx_d      = idx_q + LEN_W'(1);
            w_pat_step = 1'b1;
            state_d    = S_READ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      seed_q  <= '0;
      idx_q   <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      seed_q  <= seed_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
    end
  end

  // Outputs decode from registered state only, so they hold under waitrequest
  always_comb begin
    busy           = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_RWAIT);
    done           = (state_q == S_DONE);
    pass           = (state_q == S_DONE) && (err_q == '0);
    err_count      = err_q;
    first_err_addr = ferr_q;
    avm_write      = (state_q == S_WRITE);
    avm_read       = (state_q == S_READ);
    avm_address    = (avm_write || avm_read) ? w_cur_addr : '0;
    avm_writedata  = avm_write ? w_pattern : 32'h0;
    avm_byteenable = 4'hF;
  end

endmodule
`default_nettype wire

// File: tb/tb_lab1_memtest_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_lab1_memtest_master
// Purpose  : Self-checking bench for lab1_memtest_master with an Avalon RAM
//            slave model (latency 1, optional waitrequest, read corruption)
//            and a reference model of the expected test outcome.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lab1_memtest_master;

  localparam int ADDR_W = 32;
  localparam int LEN_W  = 14;
  localparam int ERR_W  = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  num_words;
  logic [31:0]       seed;
  logic              busy, done, pass;
  logic [ERR_W-1:0]  err_count;
  logic [ADDR_W-1:0] first_err_addr;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read, avm_write;
  logic [31:0]       avm_writedata;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;

  always #5 clk = ~clk;

  lab1_memtest_master #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W),
    .ERR_W  (ERR_W)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .base_addr         (base_addr),
    .num_words         (num_words),
    .seed              (seed),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .err_count         (err_count),
    .first_err_addr    (first_err_addr),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference pattern straight from the definition of P(i)
  function automatic logic [31:0] pat(input logic [31:0] s, input int i);
    logic [31:0] r;
`ifdef MEMTEST_LFSR_EN
    r = (s == 32'h0) ? 32'h1 : s;
    for (int j = 0; j < i; j++) r = {1'b0, r[31:1]} ^ (r[0] ? 32'h8020_0003 : 32'h0);
`else
    r = s ^ 32'(i);
`endif
    return r;
  endfunction

  // ---------------- slave model state ----------------
  logic [31:0] mem      [logic [31:0]];
  int          wcnt     [logic [31:0]];
  bit          flip_set [logic [31:0]];
  int          stall_left = 0;
  bit          rand_ws = 0, spur_en = 0;
  int          stall_cnt = 0, n_wr = 0, n_rd = 0, n_req = 0, viol = 0;
  bit          rd_pend = 0;
  logic [31:0] rd_data = 0;
  bit          prev_stalled = 0;
  logic        prev_rd = 0, prev_wr = 0;
  logic [31:0] prev_addr = 0, prev_data = 0;

  logic [31:0] cfg_base, cfg_seed;
  int          cfg_n;

  // RAM slave: decides waitrequest and read data once per cycle at negedge
  initial begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'h0;
    forever begin
      @(negedge clk);
      avm_readdatavalid = rd_pend;
      avm_readdata      = rd_pend ? rd_data : 32'hDEAD_BEEF;
      if (!rd_pend && spur_en && ($urandom_range(0, 3) == 0)) avm_readdatavalid = 1'b1;
      rd_pend = 1'b0;
      if (!reset_n) begin
        avm_waitrequest = 1'b0;
        prev_stalled    = 1'b0;
      end else begin
        if (avm_read && avm_write) viol++;
        if (prev_stalled && ((avm_read !== prev_rd) || (avm_write !== prev_wr) ||
            (avm_address !== prev_addr) || (prev_wr && (avm_writedata !== prev_data)))) viol++;
        if (avm_read || avm_write) begin
          n_req++;
          if (stall_left > 0) begin
            avm_waitrequest = 1'b1;
            stall_left--;
          end else begin
            avm_waitrequest = rand_ws && ($urandom_range(0, 3) == 0);
          end
        end else begin
          avm_waitrequest = 1'b0;
        end
        prev_stalled = avm_waitrequest;
        prev_rd      = avm_read;
        prev_wr      = avm_write;
        prev_addr    = avm_address;
        prev_data    = avm_writedata;
        if (avm_waitrequest) begin
          stall_cnt++;
        end else if (avm_write) begin
          mem[avm_address]  = avm_writedata;
          wcnt[avm_address] = wcnt.exists(avm_address) ? wcnt[avm_address] + 1 : 1;
          n_wr++;
        end else if (avm_read) begin
          n_rd++;
          rd_pend = 1'b1;
          rd_data = mem.exists(avm_address) ? mem[avm_address] : 32'hBAD0_0000;
          if (flip_set.exists(avm_address)) rd_data = rd_data ^ 32'h1;
        end
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Launch a test; returns at the negedge of cycle k+1 after checking it
  task automatic do_start(input logic [31:0] b, input int n, input logic [31:0] s,
                          input int stall_first, input bit rws, input bit spur, input int flip_mode);
    flip_set.delete(); mem.delete(); wcnt.delete();
    n_wr = 0; n_rd = 0; n_req = 0; stall_cnt = 0; viol = 0;
    stall_left = stall_first; rand_ws = rws; spur_en = spur;
    cfg_base = b & 32'hFFFF_FFFC; cfg_n = n; cfg_seed = s;
    if (flip_mode == 1) flip_set[32'h8] = 1'b1;
    else if (flip_mode == 2)
      for (int i = 0; i < n; i++) if ($urandom_range(0, 3) == 0) flip_set[cfg_base + 32'(4 * i)] = 1'b1;
    base_addr = b; num_words = LEN_W'(n); seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0; base_addr = $urandom; num_words = LEN_W'($urandom); seed = $urandom;
    check_eq("k1_busy",  64'(busy),      64'(n != 0));
    check_eq("k1_done",  64'(done),      64'(n == 0));
    check_eq("k1_write", 64'(avm_write), 64'(n != 0));
    if (n != 0) begin
      check_eq("k1_addr",  64'(avm_address),   64'(cfg_base));
      check_eq("k1_wdata", 64'(avm_writedata), 64'(pat(s, 0)));
    end
  endtask

  // Wait for done (bounded) and compare the outcome against the model
  task automatic finish_run(input bit pulse);
    int lat, lim, bad, dup, ee;
    logic [31:0] fe, a;
    lat = 1;
    lim = 6 * cfg_n + 100;
    while (!done && lat < lim) begin
      if (pulse && lat == 3) begin
        start = 1'b1; base_addr = $urandom; num_words = LEN_W'($urandom_range(1, 5)); seed = $urandom;
      end
      @(negedge clk);
      lat++;
      start = 1'b0;
    end
    check_eq("done_seen", 64'(done), 64'd1);
    check_eq("latency",   64'(lat),  64'(1 + 3 * cfg_n + stall_cnt));
    bad = 0; dup = 0; ee = 0; fe = 32'h0;
    for (int i = 0; i < cfg_n; i++) begin
      a = cfg_base + 32'(4 * i);
      if (!mem.exists(a)) bad++;
      else if (mem[a] !== pat(cfg_seed, i)) bad++;
      if (!wcnt.exists(a)) dup++;
      else if (wcnt[a] != 1) dup++;
      if (flip_set.exists(a)) begin
        if (ee == 0) fe = a;
        ee++;
      end
    end
    if (ee > 65535) ee = 65535;
    check_eq("mem_data_bad",    64'(bad),  64'd0);
    check_eq("write_count_bad", 64'(dup),  64'd0);
    check_eq("n_writes",        64'(n_wr), 64'(cfg_n));
    check_eq("n_reads",         64'(n_rd), 64'(cfg_n));
    check_eq("n_req_cycles",    64'(n_req), 64'(2 * cfg_n + stall_cnt));
    check_eq("protocol_viol",   64'(viol), 64'd0);
    check_eq("busy_end",        64'(busy), 64'd0);
    check_eq("pass",            64'(pass), 64'(ee == 0));
    check_eq("err_count",       64'(err_count), 64'(ee));
    check_eq("first_err_addr",  64'(first_err_addr), 64'(fe));
  endtask

  initial begin
    int w;
    logic [31:0] rb;
    reset_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; seed = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy",  64'(busy), 64'd0);
    check_eq("rst_done",  64'(done), 64'd0);
    check_eq("rst_pass",  64'(pass), 64'd0);
    check_eq("rst_err",   64'(err_count), 64'd0);
    check_eq("rst_ferr",  64'(first_err_addr), 64'd0);
    check_eq("rst_rdwr",  64'({avm_read, avm_write}), 64'd0);
    check_eq("rst_addr",  64'(avm_address), 64'd0);
    check_eq("rst_wdata", 64'(avm_writedata), 64'd0);
    check_eq("rst_be",    64'(avm_byteenable), 64'hF);
    reset_n = 1'b1;
    @(negedge clk);

    // Ideal RAM, 4 words
    do_start(32'h0, 4, 32'hA5A5_0000, 0, 0, 0, 0);
    finish_run(0);
    // Bit 0 of word at 0x8 corrupted on read
    do_start(32'h0, 4, 32'hA5A5_0000, 0, 0, 0, 1);
    finish_run(0);
    // Three waitrequest cycles on the first write
    do_start(32'h0, 4, 32'hA5A5_0000, 3, 0, 0, 0);
    finish_run(0);
    check_eq("stall_cycles", 64'(stall_cnt), 64'd3);
    // Zero-length test
    do_start(32'h100, 0, 32'h1234_5678, 0, 0, 0, 0);
    finish_run(0);

    // Reset while waiting for read data
    do_start(32'h40, 4, 32'h0F0F_0000, 0, 0, 0, 0);
    w = 0;
    while (!(busy && !avm_read && !avm_write) && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_eq("reach_rwait", 64'(w < 100), 64'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("rw_rst_busy", 64'(busy), 64'd0);
    check_eq("rw_rst_done", 64'(done), 64'd0);
    check_eq("rw_rst_rdwr", 64'({avm_read, avm_write}), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    do_start(32'h40, 4, 32'h0F0F_0000, 0, 0, 0, 0);
    finish_run(0);

    // Zero seed
    do_start(32'h200, 5, 32'h0, 0, 0, 0, 0);
    finish_run(0);
    rb = mem.exists(32'h200) ? mem[32'h200] : 32'hFFFF_FFFF;
`ifdef MEMTEST_LFSR_EN
    check_eq("seed0_first_word", 64'(rb), 64'h1);
`else
    check_eq("seed0_first_word", 64'(rb), 64'h0);
`endif

    // Randomized runs: wrap-around bases, stalls, spurious readdatavalid,
    // scattered corruption and a start pulse while busy
    for (int t = 0; t < 10; t++) begin
      logic [31:0] b;
      b = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      do_start(b, $urandom_range(1, 10), $urandom, $urandom_range(0, 2), 1'b1, 1'b1, 2);
      finish_run(1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
